// File: rtl/udp_tx_header_inserter.sv
`default_nettype none
// ============================================================================
// udp_tx_header_inserter: prepends the 8-byte UDP header and forwards payload
// to IP TX. Optional length enforcement: UDP_TX_LENGTH_ENFORCE_EN. Rev 1.0
// ============================================================================
module udp_tx_header_inserter #(
  parameter logic [15:0] MAX_PAYLOAD = 16'd1472,
  parameter logic [7:0]  IP_PROTOCOL = 8'd17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        udp_tx_start,
  input  logic [31:0] udp_tx_dst_ip_addr,
  input  logic [15:0] udp_tx_dst_port,
  input  logic [15:0] udp_tx_src_port,
  input  logic [15:0] udp_tx_data_length,
  output logic [1:0]  udp_tx_result,
  input  logic [7:0]  udp_tx_data_out,
  input  logic        udp_tx_data_out_valid,
  input  logic        udp_tx_data_out_last,
  output logic        udp_tx_data_out_ready,
  output logic        ip_tx_start,
  output logic [31:0] ip_tx_dst_ip_addr,
  output logic [7:0]  ip_tx_protocol,
  output logic [15:0] ip_tx_data_length,
  input  logic [1:0]  ip_tx_result,
  output logic [7:0]  ip_tx_data,
  output logic        ip_tx_data_valid,
  output logic        ip_tx_data_last,
  input  logic        ip_tx_data_ready
);

  localparam logic [1:0] c_RES_NONE    = 2'b00;
  localparam logic [1:0] c_RES_SENDING = 2'b01;
  localparam logic [1:0] c_RES_ERR     = 2'b10;
  localparam logic [1:0] c_RES_SENT    = 2'b11;

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_WAIT_IP = 3'd1;
  localparam logic [2:0] c_HDR     = 3'd2;
  localparam logic [2:0] c_PAYLOAD = 3'd3;
  localparam logic [2:0] c_DONE    = 3'd4;
  localparam logic [2:0] c_ERR     = 3'd5;
`ifdef UDP_TX_LENGTH_ENFORCE_EN
  localparam logic [2:0] c_PAD     = 3'd6;
  localparam logic [2:0] c_DROP    = 3'd7;
`endif

  logic [2:0]  r_state;
  logic [1:0]  r_result;
  logic [31:0] r_dst_ip;
  logic [15:0] r_dst_port;
  logic [15:0] r_src_port;
  logic [15:0] r_length;
  logic [15:0] r_len8;
  logic [15:0] r_byte_cnt;
  logic [2:0]  r_hdr_idx;
  logic        r_ip_start;

  logic        w_abort;
  logic        w_pay_xfer;
  logic [15:0] w_cnt_next;
  logic [7:0]  w_hdr_byte;
`ifdef UDP_TX_LENGTH_ENFORCE_EN
  logic        w_final;
  assign w_final = (w_cnt_next == r_length);
`endif

  // An IP-side error kills the current beat in the same cycle it is seen.
  assign w_abort    = (ip_tx_result == c_RES_ERR);
  assign w_pay_xfer = udp_tx_data_out_valid & ip_tx_data_ready & ~w_abort;
  assign w_cnt_next = r_byte_cnt + 16'd1;

  assign udp_tx_result     = r_result;
  assign ip_tx_start       = r_ip_start;
  assign ip_tx_dst_ip_addr = r_dst_ip;
  assign ip_tx_protocol    = IP_PROTOCOL;
  assign ip_tx_data_length = r_len8;

  always_comb begin
    w_hdr_byte = 8'h00;
    case (r_hdr_idx)
      3'd0:    w_hdr_byte = r_src_port[15:8];
      3'd1:    w_hdr_byte = r_src_port[7:0];
      3'd2:    w_hdr_byte = r_dst_port[15:8];
      3'd3:    w_hdr_byte = r_dst_port[7:0];
      3'd4:    w_hdr_byte = r_len8[15:8];
      3'd5:    w_hdr_byte = r_len8[7:0];
      default: w_hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    ip_tx_data            = 8'h00;
    ip_tx_data_valid      = 1'b0;
    ip_tx_data_last       = 1'b0;
    udp_tx_data_out_ready = 1'b0;
    case (r_state)
      c_HDR: begin
        ip_tx_data       = w_hdr_byte;
        ip_tx_data_valid = 1'b1;
        ip_tx_data_last  = (r_hdr_idx == 3'd7) && (r_length == 16'd0);
      end
      c_PAYLOAD: begin
        ip_tx_data            = udp_tx_data_out;
        ip_tx_data_valid      = udp_tx_data_out_valid & ~w_abort;
        udp_tx_data_out_ready = ip_tx_data_ready & ~w_abort;
`ifdef UDP_TX_LENGTH_ENFORCE_EN
        ip_tx_data_last       = w_final;
`else
        ip_tx_data_last       = udp_tx_data_out_last;
`endif
      end
`ifdef UDP_TX_LENGTH_ENFORCE_EN
      c_PAD: begin
        ip_tx_data_valid = 1'b1;
        ip_tx_data_last  = w_final;
      end
      c_DROP: udp_tx_data_out_ready = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_IDLE;
      r_result   <= c_RES_NONE;
      r_dst_ip   <= 32'd0;
      r_dst_port <= 16'd0;
      r_src_port <= 16'd0;
      r_length   <= 16'd0;
      r_len8     <= 16'd0;
      r_byte_cnt <= 16'd0;
      r_hdr_idx  <= 3'd0;
      r_ip_start <= 1'b0;
    end else begin
      r_ip_start <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (udp_tx_start) begin
            r_dst_ip   <= udp_tx_dst_ip_addr;
            r_dst_port <= udp_tx_dst_port;
            r_src_port <= udp_tx_src_port;
            r_length   <= udp_tx_data_length;
            r_len8     <= udp_tx_data_length + 16'd8;
            if (udp_tx_data_length > MAX_PAYLOAD) begin
              r_result <= c_RES_ERR;
              r_state  <= c_ERR;
            end else begin
              r_ip_start <= 1'b1;
              r_result   <= c_RES_SENDING;
              r_state    <= c_WAIT_IP;
            end
          end
        end
        c_WAIT_IP: begin
          if (ip_tx_result == c_RES_SENDING) begin
            r_hdr_idx <= 3'd0;
            r_state   <= c_HDR;
          end else if (w_abort) begin
            r_result <= c_RES_ERR;
            r_state  <= c_ERR;
          end
        end
        c_HDR: begin
          if (w_abort) begin
            r_result <= c_RES_ERR;
            r_state  <= c_ERR;
          end else if (ip_tx_data_ready) begin
            r_hdr_idx <= r_hdr_idx + 3'd1;
            if (r_hdr_idx == 3'd7) begin
              r_byte_cnt <= 16'd0;
              if (r_length == 16'd0) begin
                r_result <= c_RES_SENT;
                r_state  <= c_DONE;
              end else begin
                r_state <= c_PAYLOAD;
              end
            end
          end
        end
        c_PAYLOAD: begin
          if (w_abort) begin
            r_result <= c_RES_ERR;
            r_state  <= c_ERR;
          end else if (w_pay_xfer) begin
            r_byte_cnt <= w_cnt_next;
`ifdef UDP_TX_LENGTH_ENFORCE_EN
            // Declared length wins: early last pads, missing last drops the excess.
            if (w_final) begin
              if (udp_tx_data_out_last) begin
                r_result <= c_RES_SENT;
                r_state  <= c_DONE;
              end else begin
                r_state <= c_DROP;
              end
            end else if (udp_tx_data_out_last) begin
              r_state <= c_PAD;
            end
`else
            if (udp_tx_data_out_last) begin
              r_result <= c_RES_SENT;
              r_state  <= c_DONE;
            end
`endif
          end
        end
`ifdef UDP_TX_LENGTH_ENFORCE_EN
        c_PAD: begin
          if (w_abort) begin
            r_result <= c_RES_ERR;
            r_state  <= c_ERR;
          end else if (ip_tx_data_ready) begin
            r_byte_cnt <= w_cnt_next;
            if (w_final) begin
              r_result <= c_RES_SENT;
              r_state  <= c_DONE;
            end
          end
        end
        c_DROP: begin
          if (udp_tx_data_out_valid && udp_tx_data_out_last) begin
            r_result <= c_RES_ERR;
            r_state  <= c_ERR;
          end
        end
`endif
        c_DONE, c_ERR: begin
          if (!udp_tx_start) r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_header_inserter.sv
`default_nettype none
// tb_udp_tx_header_inserter: directed self-checking bench for udp_tx_header_inserter.
`timescale 1ns/1ps
module tb_udp_tx_header_inserter;

  logic        clk = 1'b0;
  logic        reset;
  logic        udp_tx_start;
  logic [31:0] udp_tx_dst_ip_addr;
  logic [15:0] udp_tx_dst_port;
  logic [15:0] udp_tx_src_port;
  logic [15:0] udp_tx_data_length;
  logic [1:0]  udp_tx_result;
  logic [7:0]  udp_tx_data_out;
  logic        udp_tx_data_out_valid;
  logic        udp_tx_data_out_last;
  logic        udp_tx_data_out_ready;
  logic        ip_tx_start;
  logic [31:0] ip_tx_dst_ip_addr;
  logic [7:0]  ip_tx_protocol;
  logic [15:0] ip_tx_data_length;
  logic [1:0]  ip_tx_result;
  logic [7:0]  ip_tx_data;
  logic        ip_tx_data_valid;
  logic        ip_tx_data_last;
  logic        ip_tx_data_ready;

  always #5 clk = ~clk;

  udp_tx_header_inserter dut (
    .clk(clk), .reset(reset),
    .udp_tx_start(udp_tx_start), .udp_tx_dst_ip_addr(udp_tx_dst_ip_addr),
    .udp_tx_dst_port(udp_tx_dst_port), .udp_tx_src_port(udp_tx_src_port),
    .udp_tx_data_length(udp_tx_data_length), .udp_tx_result(udp_tx_result),
    .udp_tx_data_out(udp_tx_data_out), .udp_tx_data_out_valid(udp_tx_data_out_valid),
    .udp_tx_data_out_last(udp_tx_data_out_last), .udp_tx_data_out_ready(udp_tx_data_out_ready),
    .ip_tx_start(ip_tx_start), .ip_tx_dst_ip_addr(ip_tx_dst_ip_addr),
    .ip_tx_protocol(ip_tx_protocol), .ip_tx_data_length(ip_tx_data_length),
    .ip_tx_result(ip_tx_result), .ip_tx_data(ip_tx_data),
    .ip_tx_data_valid(ip_tx_data_valid), .ip_tx_data_last(ip_tx_data_last),
    .ip_tx_data_ready(ip_tx_data_ready)
  );

  int compared = 0;
  int mismatched = 0;

  logic [7:0] pay [0:15];
  int         pay_n;
  logic [7:0] exp_data [0:15];
  int         exp_n;
  logic [7:0] cap_data [$];
  logic       cap_last [$];
  int         start_pulses;
  bit         cl_ready_seen;
  bit         abort_leak;
  bit         timed_out;
  logic [1:0] final_result;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request and plays client + IP layer until a final result appears.
  task automatic run_frame(input logic [15:0] len, input bit toggle_ready, input int abort_after);
    int cpi;
    int start_cyc;
    bit aborted;
    bit abort_now;
    cap_data.delete();
    cap_last.delete();
    start_pulses = 0; cl_ready_seen = 0; abort_leak = 0; timed_out = 1;
    final_result = 2'b00; cpi = 0; start_cyc = -1; aborted = 0;
    udp_tx_dst_ip_addr = 32'h0A00_0005;
    udp_tx_dst_port    = 16'd5000;
    udp_tx_src_port    = 16'd18520;
    udp_tx_data_length = len;
    udp_tx_start       = 1'b1;
    ip_tx_result       = 2'b00;
    for (int cyc = 0; cyc < 300; cyc++) begin
      abort_now = 0;
      udp_tx_data_out_valid = (cpi < pay_n);
      udp_tx_data_out       = (cpi < pay_n) ? pay[cpi] : 8'h00;
      udp_tx_data_out_last  = (cpi == pay_n - 1);
      ip_tx_data_ready      = toggle_ready ? (cyc % 2 == 1) : 1'b1;
      if (start_cyc >= 0 && cyc >= start_cyc + 2 && !aborted) ip_tx_result = 2'b01;
      if (abort_after >= 0 && !aborted && ip_tx_data_ready &&
          cap_data.size() >= 8 + abort_after) begin
        ip_tx_result = 2'b10;
        aborted = 1;
        abort_now = 1;
      end
      #1;
      if (ip_tx_start) begin
        start_pulses++;
        if (start_cyc < 0) start_cyc = cyc;
      end
      if (udp_tx_data_out_ready) cl_ready_seen = 1;
      if (abort_now && ((ip_tx_data_valid && ip_tx_data_ready) || udp_tx_data_out_ready))
        abort_leak = 1;
      if (ip_tx_data_valid && ip_tx_data_ready) begin
        cap_data.push_back(ip_tx_data);
        cap_last.push_back(ip_tx_data_last);
      end
      if (udp_tx_data_out_valid && udp_tx_data_out_ready) cpi++;
      tick();
      udp_tx_start = 1'b0;
      if (udp_tx_result == 2'b11 || udp_tx_result == 2'b10) begin
        final_result = udp_tx_result;
        timed_out = 0;
        break;
      end
    end
    udp_tx_data_out_valid = 1'b0;
    udp_tx_data_out_last  = 1'b0;
    ip_tx_result          = 2'b00;
    tick();
  endtask

  // Compares captured bytes and last flags against exp_data[0:exp_n-1].
  task automatic compare_stream(input string name);
    bit bad_last;
    compared++;
    if (timed_out) begin
      mismatched++;
      $display("FAIL %s_timeout: no final result within cycle budget", name);
    end
    compared++;
    if (cap_data.size() !== exp_n) begin
      mismatched++;
      $display("FAIL %s_count: got %0d beats, expected %0d", name, cap_data.size(), exp_n);
    end
    for (int i = 0; i < exp_n; i++) begin
      compared++;
      if (i >= cap_data.size()) begin
        mismatched++;
        $display("FAIL %s_byte%0d: missing, expected %02h", name, i, exp_data[i]);
      end else if (cap_data[i] !== exp_data[i]) begin
        mismatched++;
        $display("FAIL %s_byte%0d: got %02h, expected %02h", name, i, cap_data[i], exp_data[i]);
      end
    end
    bad_last = 0;
    for (int i = 0; i < cap_data.size(); i++)
      if (cap_last[i] !== (i == exp_n - 1)) bad_last = 1;
    compared++;
    if (bad_last) begin
      mismatched++;
      $display("FAIL %s_last: last flag not only on beat %0d", name, exp_n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    udp_tx_start = 0; udp_tx_dst_ip_addr = 0; udp_tx_dst_port = 0; udp_tx_src_port = 0;
    udp_tx_data_length = 0; udp_tx_data_out = 0; udp_tx_data_out_valid = 0;
    udp_tx_data_out_last = 0; ip_tx_result = 0; ip_tx_data_ready = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
    compared++;
    if (udp_tx_result !== 2'b00) begin mismatched++; $display("FAIL reset_result: got %b, expected 00", udp_tx_result); end
    compared++;
    if ({ip_tx_start, ip_tx_data_valid, ip_tx_data_last, udp_tx_data_out_ready} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_ctrl: got start/valid/last/ready %b%b%b%b, expected 0000",
               ip_tx_start, ip_tx_data_valid, ip_tx_data_last, udp_tx_data_out_ready);
    end
    compared++;
    if (ip_tx_data_length !== 16'd0 || ip_tx_dst_ip_addr !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_latched: got len %h ip %h, expected 0", ip_tx_data_length, ip_tx_dst_ip_addr);
    end
    compared++;
    if (ip_tx_protocol !== 8'd17) begin mismatched++; $display("FAIL reset_protocol: got %0d, expected 17", ip_tx_protocol); end
  endtask

  task automatic test_basic();
    pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF; pay_n = 4;
    exp_data[0] = 8'h48; exp_data[1] = 8'h58; exp_data[2] = 8'h13; exp_data[3] = 8'h88;
    exp_data[4] = 8'h00; exp_data[5] = 8'h0C; exp_data[6] = 8'h00; exp_data[7] = 8'h00;
    exp_data[8] = 8'hDE; exp_data[9] = 8'hAD; exp_data[10] = 8'hBE; exp_data[11] = 8'hEF;
    exp_n = 12;
    run_frame(16'd4, 1'b0, -1);
    compare_stream("basic");
    compared++;
    if (final_result !== 2'b11) begin mismatched++; $display("FAIL basic_result: got %b, expected 11", final_result); end
    compared++;
    if (start_pulses !== 1) begin mismatched++; $display("FAIL basic_start_pulse: got %0d cycles, expected 1", start_pulses); end
    compared++;
    if (ip_tx_data_length !== 16'd12) begin mismatched++; $display("FAIL basic_ip_len: got %0d, expected 12", ip_tx_data_length); end
    compared++;
    if (ip_tx_dst_ip_addr !== 32'h0A00_0005) begin mismatched++; $display("FAIL basic_dst_ip: got %h, expected 0a000005", ip_tx_dst_ip_addr); end
    compared++;
    if (udp_tx_result !== 2'b11) begin mismatched++; $display("FAIL basic_result_held: got %b in idle, expected 11", udp_tx_result); end
  endtask

  task automatic test_zero_length();
    pay_n = 0;
    exp_data[0] = 8'h48; exp_data[1] = 8'h58; exp_data[2] = 8'h13; exp_data[3] = 8'h88;
    exp_data[4] = 8'h00; exp_data[5] = 8'h08; exp_data[6] = 8'h00; exp_data[7] = 8'h00;
    exp_n = 8;
    run_frame(16'd0, 1'b0, -1);
    compare_stream("zero_len");
    compared++;
    if (cl_ready_seen !== 1'b0) begin mismatched++; $display("FAIL zero_len_client_ready: got 1, expected never 1"); end
    compared++;
    if (final_result !== 2'b11) begin mismatched++; $display("FAIL zero_len_result: got %b, expected 11", final_result); end
  endtask

  task automatic test_oversize();
    bit retrig;
    udp_tx_data_length = 16'd1500;
    udp_tx_start = 1'b1;
    tick();
    compared++;
    if (udp_tx_result !== 2'b10) begin mismatched++; $display("FAIL oversize_result: got %b, expected 10", udp_tx_result); end
    retrig = 0;
    for (int i = 0; i < 6; i++) begin
      if (ip_tx_start || udp_tx_result !== 2'b10) retrig = 1;
      tick();
    end
    compared++;
    if (retrig) begin mismatched++; $display("FAIL oversize_hold: got start pulse or result change, expected steady 10"); end
    udp_tx_start = 1'b0;
    tick(); tick();
    compared++;
    if (udp_tx_result !== 2'b10 || ip_tx_start !== 1'b0) begin
      mismatched++;
      $display("FAIL oversize_release: got result %b start %b, expected 10 0", udp_tx_result, ip_tx_start);
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 16; i++) pay[i] = 8'(8'h10 + i);
    pay_n = 16;
    run_frame(16'd16, 1'b1, 5);
    compared++;
    if (cap_data.size() !== 13) begin mismatched++; $display("FAIL abort_beats: got %0d, expected 13", cap_data.size()); end
    compared++;
    if (final_result !== 2'b10) begin mismatched++; $display("FAIL abort_result: got %b, expected 10", final_result); end
    compared++;
    if (abort_leak !== 1'b0) begin mismatched++; $display("FAIL abort_same_cycle: got beat/ready in abort cycle, expected none"); end
    compared++;
    if (udp_tx_data_out_ready !== 1'b0) begin mismatched++; $display("FAIL abort_ready: got 1, expected 0"); end
    compared++;
    if (cap_data.size() == 13 && cap_data[12] !== 8'h14) begin
      mismatched++;
      $display("FAIL abort_last_byte: got %02h, expected 14", cap_data[12]);
    end
  endtask

`ifdef UDP_TX_LENGTH_ENFORCE_EN
  task automatic test_enforce_pad();
    pay[0] = 8'hA1; pay[1] = 8'hA2; pay[2] = 8'hA3; pay_n = 3;
    exp_data[0] = 8'h48; exp_data[1] = 8'h58; exp_data[2] = 8'h13; exp_data[3] = 8'h88;
    exp_data[4] = 8'h00; exp_data[5] = 8'h0E; exp_data[6] = 8'h00; exp_data[7] = 8'h00;
    exp_data[8] = 8'hA1; exp_data[9] = 8'hA2; exp_data[10] = 8'hA3;
    exp_data[11] = 8'h00; exp_data[12] = 8'h00; exp_data[13] = 8'h00;
    exp_n = 14;
    run_frame(16'd6, 1'b0, -1);
    compare_stream("pad");
    compared++;
    if (final_result !== 2'b11) begin mismatched++; $display("FAIL pad_result: got %b, expected 11", final_result); end
  endtask

  task automatic test_enforce_drop();
    pay[0] = 8'hB1; pay[1] = 8'hB2; pay[2] = 8'hB3; pay[3] = 8'hB4; pay_n = 4;
    exp_data[0] = 8'h48; exp_data[1] = 8'h58; exp_data[2] = 8'h13; exp_data[3] = 8'h88;
    exp_data[4] = 8'h00; exp_data[5] = 8'h0A; exp_data[6] = 8'h00; exp_data[7] = 8'h00;
    exp_data[8] = 8'hB1; exp_data[9] = 8'hB2;
    exp_n = 10;
    run_frame(16'd2, 1'b0, -1);
    compare_stream("drop");
    compared++;
    if (final_result !== 2'b10) begin mismatched++; $display("FAIL drop_result: got %b, expected 10", final_result); end
  endtask
`endif

  task automatic test_reset_mid();
    int beats;
    bit found;
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04; pay_n = 4;
    udp_tx_data_length = 16'd4;
    udp_tx_start = 1'b1;
    ip_tx_result = 2'b01;
    ip_tx_data_ready = 1'b1;
    beats = 0;
    found = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (ip_tx_data_valid && beats == 2) begin
        found = 1;
        break;
      end
      if (ip_tx_data_valid && ip_tx_data_ready) beats++;
      tick();
      udp_tx_start = 1'b0;
    end
    compared++;
    if (!found) begin mismatched++; $display("FAIL reset_mid_reach: header byte 3 never presented"); end
    reset = 1'b1;
    tick();
    compared++;
    if (ip_tx_data_valid !== 1'b0 || udp_tx_result !== 2'b00) begin
      mismatched++;
      $display("FAIL reset_mid: got valid %b result %b, expected 0 00", ip_tx_data_valid, udp_tx_result);
    end
    compared++;
    if (ip_tx_data_length !== 16'd0 || udp_tx_data_out_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_fields: got len %0d ready %b, expected 0 0", ip_tx_data_length, udp_tx_data_out_ready);
    end
    reset = 1'b0;
    ip_tx_result = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_oversize();
    test_abort();
`ifdef UDP_TX_LENGTH_ENFORCE_EN
    test_enforce_pad();
    test_enforce_drop();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/udp_tx_header_inserter.md
Name: udp_tx_header_inserter

Overview:
- UDP transmit engine sitting between the UDP port arbiter's muxed client interface and the IP transmit layer.
- Accepts one datagram request (start plus destination IP, ports and payload length).
- Emits the 8-byte UDP header, then passes the client payload through to IP TX with a ready/valid handshake.
- Reports a 2-bit result code back to the granted client.

Parameters:
- MAX_PAYLOAD, 16'd1472, largest accepted payload length in bytes; larger requests are rejected with ERR.
- IP_PROTOCOL, 8'd17, value driven on ip_tx_protocol.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- udp_tx_start  in  1  request level from arbiter.
- udp_tx_dst_ip_addr  in  32  destination IP.
- udp_tx_dst_port  in  16  destination port.
- udp_tx_src_port  in  16  source port.
- udp_tx_data_length  in  16  payload bytes, excluding the header.
- udp_tx_result  out  2  00 NONE, 01 SENDING, 10 ERR, 11 SENT.
- udp_tx_data_out  in  8  payload byte.
- udp_tx_data_out_valid  in  1  payload byte valid.
- udp_tx_data_out_last  in  1  final payload byte.
- udp_tx_data_out_ready  out  1  payload byte accepted.
- ip_tx_start  out  1  one-cycle IP request pulse.
- ip_tx_dst_ip_addr  out  32  latched destination IP.
- ip_tx_protocol  out  8  constant IP_PROTOCOL.
- ip_tx_data_length  out  16  udp_tx_data_length+8, latched.
- ip_tx_result  in  2  IP layer result, same encoding as udp_tx_result.
- ip_tx_data  out  8  IP payload byte.
- ip_tx_data_valid  out  1  byte valid.
- ip_tx_data_last  out  1  last byte of datagram.
- ip_tx_data_ready  in  1  IP layer accepts byte.

Behaviour:
- Reset state: IDLE. Outputs: udp_tx_result=00, ip_tx_start=0, ip_tx_data_valid=0, ip_tx_data_last=0, udp_tx_data_out_ready=0, latched fields=0.
- IDLE: if udp_tx_start=1, latch dst_ip, dst_port, src_port and length on the same edge.
  - If length>MAX_PAYLOAD: go to ERR. No IP start.
  - Otherwise: pulse ip_tx_start for one cycle, set result=01, go to WAIT_IP.
- WAIT_IP:
  - ip_tx_result=01 -> HDR with hdr_idx=0.
  - ip_tx_result=10 -> ERR.
  - Other values -> stay.
- HDR: ip_tx_data_valid=1. Byte order: src_port[15:8], src_port[7:0], dst_port[15:8], dst_port[7:0], len8[15:8], len8[7:0], 0x00, 0x00 (checksum zero).
  - hdr_idx advances only on valid&ready.
  - After byte 7 transfers: go to PAYLOAD, or to DONE if length=0. When length=0, assert ip_tx_data_last on byte 7.
- PAYLOAD: combinational pass-through.
  - ip_tx_data=udp_tx_data_out; ip_tx_data_valid=udp_tx_data_out_valid; udp_tx_data_out_ready=ip_tx_data_ready; ip_tx_data_last=udp_tx_data_out_last.
  - 16-bit byte counter increments per transfer.
  - The transfer carrying last goes to DONE.
- udp_tx_data_out_ready=0 in every state except PAYLOAD.
- DONE: result=11 (SENT).
- ERR: result=10.
- DONE and ERR hold their result until udp_tx_start is seen low, then go to IDLE. Result stays latched in IDLE until the next start; a held start never retriggers a send.
- ip_tx_result=10 in HDR or PAYLOAD aborts to ERR. Payload ready drops the same cycle (ERR is entered next edge; the in-flight beat is not counted).
- Reset mid-transfer returns to IDLE the next edge with all outputs at reset values. The partially sent datagram is abandoned.
- Width rule: len8 = data_length + 8 computed in 16 bits. Overflow is impossible because MAX_PAYLOAD ≤ 65507.

Optional Feature:
- Macro UDP_TX_LENGTH_ENFORCE_EN.
- When defined, the payload byte count is enforced against the latched length:
  - Early last (count+1<length): last is suppressed toward IP, and the block pads 0x00 bytes itself until length is reached, with ip_tx_data_last on the final pad byte.
  - Length reached without last: ip_tx_data_last is forced on byte length. Remaining client bytes are then accepted and dropped (ready=1, ip valid=0) up to and including last, and the result becomes ERR instead of SENT.
- Not defined: the client's last is passed through unchecked. The counter is used only for debug.

Test Plan:
- start, dst 10.0.0.5:5000, src 18520, length 4, payload DE AD BE EF; ip_tx_result=01 after 2 cycles; ready=1 -> ip_tx_data 48 58 13 88 00 0C 00 00 DE AD BE EF, last on EF, result 11, ip_tx_data_length=12.
- Length 0, start -> eight header bytes with length field 00 08, last on byte 8, udp_tx_data_out_ready never 1, result 11.
- Length 1500 (>1472) -> no ip_tx_start, result 10 the next cycle; holding start high keeps ERR with no retrigger.
- Length 16, ip_tx_data_ready toggling 1/0 every cycle, ip_tx_result=10 injected on payload byte 5 -> exactly 8+5 beats transferred, then result 10, ready 0.
- With UDP_TX_LENGTH_ENFORCE_EN, length 6, client sends 3 bytes with last -> 3 data bytes then 3 pad bytes 0x00, last on pad 3, result 11.
- Same macro, length 2, client sends 4 bytes -> last forced on byte 2, bytes 3–4 dropped, result 10. Reset asserted during HDR byte 3 -> the next cycle valid=0 and result=00.
